req_encoder16: RTL
==================

Name: req_encoder16

Overview:
- Sequential 16-to-4 request encoder, the inverse of the team's 4-to-16 decoder.
- Sixteen request lines are captured into a sticky pending register.
- Each pending request is presented, one at a time, as a 4-bit index under a valid/ready handshake.
- Sits between request sources (interrupt/strobe lines) and any consumer that takes a binary index, e.g. a 4-to-16 decoder.

Parameters:
- N_REQ, 16, number of request lines; fixed at 16, and other values are not supported.
- IDX_W, 4, width of the encoded index; must equal log2(N_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  capture enable; when 0, req is ignored.
- req  input  16  request lines; any cycle with a bit high (and en=1) sets that pending bit.
- code  output  4  index of the request being presented.
- valid  output  1  code holds a valid index.
- ready  input  1  consumer accepts code this cycle when valid=1.
- pending  output  16  current pending register (status/debug).
- any  output  1  OR of pending.

Behaviour:
- Single clock domain. All state is updated on the rising edge of clk; no combinational path from req to code/valid.
- Reset (rst=1 at an edge): pending=0, code=0, valid=0, any=0, state=IDLE, rotate pointer ptr=15 (when the optional feature is built).
  - Reset overrides all other activity, including a handshake or capture in the same cycle.
  - An in-flight presentation is dropped without being cleared by handshake.
- Accept condition: acc = valid & ready.
- Pending update each edge: pending <= (pending & ~onehot(code) when acc, else pending) | (req when en, else 0).
  - If a bit is cleared by acc and requested by req in the same cycle, set wins and the bit stays pending.
- FSM, two states:
  - IDLE:
    - If pending != 0, load code = select(pending), set valid=1, go to PRESENT.
    - Otherwise hold, with valid=0.
    - select() uses the registered pending value, not the incoming req.
  - PRESENT:
    - valid=1, and code is held stable while ready=0. No retraction or change is permitted even if higher-priority requests arrive.
    - On acc: valid<=0, go to IDLE.
    - Throughput is at most one index per two cycles.
- Latency: req high at edge k (en=1) -> pending bit set after edge k -> valid=1 with that code after edge k+1, provided the FSM is in IDLE with nothing of higher priority pending.
- Fixed priority (default): highest set index wins (15 > 14 > ... > 0).
- en=0: new requests are ignored; already-pending bits continue to be served and cleared normally.
- Full case: all 16 bits pending -> served in order 15, 14, ..., 0 over 32 cycles with ready held high; pending reaches 0 and any drops after the final accept.
- Empty case: pending=0 -> valid stays 0 and code holds its last value (0 after reset).
- any is combinational from the pending register only.
- ready while valid=0 has no effect.

Optional Feature:
- Macro: REQ_ENC_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - A 4-bit ptr gives the highest-priority index; search order is ptr, ptr-1, ..., wrapping 0 -> 15.
  - On each acc of index g, ptr <= g-1 mod 16 (0 wraps to 15).
  - ptr resets to 15, so the first selection matches fixed priority.
  - ptr changes only on acc.
- Undefined: ptr logic is absent and fixed highest-index priority applies. The port list is identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> code=0, valid=0, pending=0, any=0 for 10 cycles.
- Single request: en=1, req=16'h0020 for one cycle, ready=1 -> valid=1 with code=5 two edges later for one cycle; pending returns to 0.
- Stall then accept: pending=16'h8001, ready=0 for 5 cycles -> code=15 held stable with valid=1 throughout.
  - Raise ready -> code=15 accepted, then code=0 presented.
- Full case, fixed priority: req=16'hFFFF for one cycle, ready=1 -> codes 15, 14, ..., 0 in sequence, each valid for one cycle, 32 cycles total.
  - Round-robin build: with pending=16'h8003 and ptr=15 -> order 15, 1, 0. Re-request bit 15 after the first grant -> it is served after 0.
- Set-wins and enable gating: during acc of code 3, req=16'h0008 -> bit 3 remains pending and is re-presented.
  - With en=0, req=16'h0100 -> pending unchanged.
- Reset mid-presentation: valid=1, code=9, pending=16'h0201, assert rst -> next cycle valid=0, code=0, pending=0; the nine is never accepted.

Source files
------------

// File: rtl/req_encoder16_if.sv
// Bundle of the request-encoder signals: request capture, index handshake and status.
// master = encoder side, slave = request source / consumer side.
interface req_encoder16_if;
    logic        en;
    logic [15:0] req;
    logic [3:0]  code;
    logic        valid;
    logic        ready;
    logic [15:0] pending;
    logic        any;
    logic        fsm_state;

    // code/valid/ready: a transfer happens on any rising edge where valid and
    // ready are both 1; while valid=1 and ready=0, code stays frozen.
    modport master (
        input  en,
        input  req,
        input  ready,
        output code,
        output valid,
        output pending,
        output any,
        output fsm_state
    );

    modport slave (
        output en,
        output req,
        output ready,
        input  code,
        input  valid,
        input  pending,
        input  any,
        input  fsm_state
    );
endinterface

// File: rtl/req_encoder16.sv
// Sequential 16-to-4 request encoder: sticky pending register served one index at a time.
// Define REQ_ENC_ROUND_ROBIN_EN for rotating priority; otherwise highest index wins.
module req_encoder16 #(
    parameter int N_REQ = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    req_encoder16_if.master  bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]   code_q, code_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   sel;
    logic               acc;
    logic [N_REQ-1:0]   clr_mask;

    assign acc      = valid_q & bus.ready;
    assign clr_mask = acc ? (16'h0001 << code_q) : '0;

    // A bit cleared by the accept and re-requested in the same cycle stays set.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | (bus.en ? bus.req : '0);
    end

`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx;

    // Walk from the lowest priority up to ptr so the last hit is the winner.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr_q - k[IDX_W-1:0];
            if (pending_q[idx]) begin
                sel = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 4'd15;
        end else if (acc) begin
            ptr_q <= code_q - 4'd1;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pending_q[i]) begin
                sel = i[IDX_W-1:0];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (|pending_q) begin
                    code_d  = sel;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (acc) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.code      = code_q;
    assign bus.valid     = valid_q;
    assign bus.pending   = pending_q;
    assign bus.any       = |pending_q;
    assign bus.fsm_state = state_q;

endmodule
